pipe_mux_n: RTL and testbench
=============================

// Module: pipe_mux_n
// PURPOSE
//   Parametrised N-way, W-bit selector with a registered output stage and
//   valid/ready handshake. Next generation of the combinational 2/3-way muxes
//   used in the RISC-V / FPA pipeline: any input count, any width.
//   A 2-entry skid buffer holds data, so a stall on the downstream side never
//   creates a combinational ready path to the upstream side. Serves as the
//   operand-forwarding and FPA-result select stage between pipeline registers.
// PARAMETERS
//   W     32  data width per input
//   N     3   number of inputs (>=2)
//   SELW  2   select width; SELW >= $clog2(N)
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   flush      in   1       synchronous pipeline flush, drops all held data
//   in_bus     in   N*W     packed inputs; input k = in_bus[k*W +: W]
//   sel        in   SELW    binary select, sampled with in_bus
//   in_valid   in   1       upstream has data + sel
//   in_ready   out  1       block can accept this cycle
//   out_data   out  W       selected data
//   out_oor    out  1       data was produced by an out-of-range select
//   out_valid  out  1       out_data/out_oor valid
//   out_ready  in   1       downstream accepts
// BEHAVIOUR
//   - Clock and reset: one clock. Reset is asynchronous and active-low.
//     While rst_n=0: out_valid=0, out_data=0, out_oor=0, in_ready=0.
//     in_ready goes to 1 on the first clk edge after release.
//   - Select rule: for sel<N, the selected word is input[sel] and oor=0.
//     For sel>=N, the selected word is all-zero and oor=1.
//   - Accept: a transfer takes place on a clk edge when in_valid&in_ready=1.
//     Emit: a transfer takes place on a clk edge when out_valid&out_ready=1.
//   - Storage: main register M (drives the outputs) and skid register S.
//   - in_ready is a register: in_ready = !S.valid. It never depends
//     combinationally on out_ready.
//   - Latency: 1 cycle from accept to out_valid. Throughput: 1 word/cycle
//     while out_ready=1.
//   - Per-edge update, evaluated in this priority order:
//     1) flush=1: M.valid=0 and S.valid=0. A simultaneous accept is dropped.
//        Data regs hold their values. in_ready=1 on the next cycle.
//     2) M is empty, or M is emitted this edge: M takes S if S is valid,
//        otherwise M takes the accepted input. The S->M move sets S.valid=0.
//     3) M is full and not emitted, and an accept occurs: the input goes to S.
//   - Simultaneous accept and emit with S empty: M takes the new word; no bubble.
//   - Order is strictly preserved: FIFO of depth 2.
//   - out_data/out_oor stay stable while out_valid=1 and out_ready=0.
//   - Reset mid-operation: all held words are lost; no partial outputs.
//   - in_valid=0: sel and in_bus are don't-care.
// STRUCTURE
//   - Sub-module skid_buf #(W+1): generic 2-entry valid/ready buffer.
//     Payload is {oor, data}.
//   - pipe_mux_n = combinational N-way select + skid_buf + flush gating.
//   - Shared header mux_defs.vh: default W, a CLOG2 macro, and the
//     out-of-range zero constant. It is shared with mux2/mux3/dmux2.
// TESTING
//   1 Reset: assert rst_n=0 mid-stream -> out_valid=0, out_data=0 at once.
//     Release -> in_ready=1 after one edge.
//   2 N=3, W=32, in_bus={C,B,A}, sel=0,1,2 on consecutive cycles,
//     out_ready=1 -> out_data=A,B,C on cycles 1,2,3; oor=0.
//   3 sel=3 (out of range) with N=3 -> out_data=32'h0, out_oor=1.
//   4 Stall: out_ready=0 while 2 words are sent -> in_ready=0 after the 2nd
//     accept; out_data stays word1. Release -> words 1,2 emitted in order,
//     no loss and no duplicate.
//   5 flush with in_valid=1 and both entries full -> next cycle out_valid=0,
//     in_ready=1; the flushed-cycle input never appears at the output.
//   6 Random in_valid/out_ready, N=5, W=8, 10k cycles -> scoreboard matches;
//     in_ready never depends on same-cycle out_ready.

Source files
------------

// File: rtl/pipe_mux_n_pkg.sv
// Shared defaults and helpers for the N-way pipelined selector family.
package pipe_mux_n_pkg;

  localparam int DEF_W = 32;
  localparam int DEF_N = 3;

  // Number of bits needed to encode v distinct values (minimum 1).
  function automatic int clog2_int(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_mux_n_if.sv
// Handshake bundle between the upstream stage, the selector and downstream.
interface pipe_mux_n_if
  import pipe_mux_n_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int N    = DEF_N,
  parameter int SELW = clog2_int(N)
);
  logic [N*W-1:0]  in_bus;
  logic [SELW-1:0] sel;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_oor;
  logic            out_valid;
  logic            out_ready;

  // Environment side: drives the inputs and consumes the result.
  modport master (
    output in_bus, sel, in_valid, out_ready,
    input  in_ready, out_data, out_oor, out_valid
  );

  // Selector side.
  modport slave (
    input  in_bus, sel, in_valid, out_ready,
    output in_ready, out_data, out_oor, out_valid
  );
endinterface

// File: rtl/pipe_mux_n_skid_buf.sv
// Generic 2-entry valid/ready buffer. M drives the outputs, S catches the
// word accepted while M is stalled. in_ready is a flop so a downstream stall
// never reaches the upstream side combinationally.
module pipe_mux_n_skid_buf #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] m_data, s_data;
  logic          m_valid, s_valid, in_ready_q;
  logic          accept, emit, load_m;

  assign accept = in_valid & in_ready_q;
  assign emit   = m_valid & out_ready;
  assign load_m = !m_valid | emit;

  // Storage update: clear wins, then refill M (from S first), else park in S.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data     <= '0;
      s_data     <= '0;
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b0;
    end else if (clear) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (load_m) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else begin
        m_valid <= accept;
        if (accept) m_data <= in_data;
      end
      in_ready_q <= 1'b1;
    end else if (accept) begin
      s_valid    <= 1'b1;
      s_data     <= in_data;
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= !s_valid;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = m_data;
  assign out_valid = m_valid;

endmodule

// File: rtl/pipe_mux_n.sv
// N-way, W-bit selector with a registered, skid-buffered output stage.
// An out-of-range select yields an all-zero word tagged with out_oor.
module pipe_mux_n
  import pipe_mux_n_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int N    = DEF_N,
  parameter int SELW = clog2_int(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  pipe_mux_n_if.slave    bus
);

  logic [W-1:0] sel_word;
  logic         sel_oor;
  logic [W:0]   buf_out;

  // Combinational select; default covers every sel >= N.
  always_comb begin
    sel_word = '0;
    sel_oor  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (bus.sel == SELW'(k)) begin
        sel_word = bus.in_bus[k*W +: W];
        sel_oor  = 1'b0;
      end
    end
  end

  // A word offered during flush must never enter storage.
  pipe_mux_n_skid_buf #(.DW(W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .in_data   ({sel_oor, sel_word}),
    .in_valid  (bus.in_valid & !flush),
    .in_ready  (bus.in_ready),
    .out_data  (buf_out),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign bus.out_oor  = buf_out[W];
  assign bus.out_data = buf_out[W-1:0];

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: directed checks on a 3x32 instance, randomized
// scoreboard run on a 5x8 instance.
module tb_pipe_mux_n;

  logic clk;
  logic rst_n;
  logic flush_a, flush_b;
  int   n_err;
  int   n_checks;

  pipe_mux_n_if #(.W(32), .N(3), .SELW(2)) ifa ();
  pipe_mux_n_if #(.W(8),  .N(5), .SELW(3)) ifb ();

  pipe_mux_n #(.W(32), .N(3), .SELW(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(ifa.slave));
  pipe_mux_n #(.W(8), .N(5), .SELW(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(ifb.slave));

  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WB = 32'hBBBB_0002;
  localparam logic [31:0] WC = 32'hCCCC_0003;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.sel = '0; ifa.in_bus = '0;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.sel = '0; ifb.in_bus = '0;
    flush_a = 1'b0; flush_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    n_checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0 || ifa.out_oor !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b data=%h oor=%b required 0/0/0",
               ifa.out_valid, ifa.out_data, ifa.out_oor);
    end
    n_checks++;
    if (ifa.in_ready !== 1'b0 || ifb.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready: a=%b b=%b required 0", ifa.in_ready, ifb.in_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ifa.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL release_before_edge: in_ready=%b required 0", ifa.in_ready);
    end
    tick();
    n_checks++;
    if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release_after_edge: a=%b b=%b required 1", ifa.in_ready, ifb.in_ready);
    end
  endtask

  task automatic test_select();
    logic [31:0] exp_w [3];
    exp_w[0] = WA; exp_w[1] = WB; exp_w[2] = WC;
    ifa.in_bus    = {WC, WB, WA};
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 1'b1;
    for (int s = 0; s < 3; s++) begin
      ifa.sel = 2'(s);
      tick();
      n_checks++;
      if (ifa.out_valid !== 1'b1 || ifa.out_data !== exp_w[s] || ifa.out_oor !== 1'b0) begin
        n_err++;
        $display("FAIL select_%0d: valid=%b data=%h oor=%b required 1/%h/0",
                 s, ifa.out_valid, ifa.out_data, ifa.out_oor, exp_w[s]);
      end
    end
    ifa.in_valid = 1'b0;
    tick();
    n_checks++;
    if (ifa.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL select_drain: out_valid=%b required 0", ifa.out_valid);
    end
  endtask

  task automatic test_oor();
    ifa.in_bus   = {WC, WB, WA};
    ifa.sel      = 2'd3;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    n_checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== 32'h0 || ifa.out_oor !== 1'b1) begin
      n_err++;
      $display("FAIL oor_select: valid=%b data=%h oor=%b required 1/00000000/1",
               ifa.out_valid, ifa.out_data, ifa.out_oor);
    end
    tick();
    n_checks++;
    if (ifa.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL oor_drain: out_valid=%b required 0", ifa.out_valid);
    end
  endtask

  task automatic test_stall();
    ifa.in_bus    = {WC, WB, WA};
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.sel       = 2'd0;
    tick();
    n_checks++;
    if (ifa.out_data !== WA || ifa.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_first: data=%h in_ready=%b required %h/1", ifa.out_data, ifa.in_ready, WA);
    end
    ifa.sel = 2'd1;
    tick();
    n_checks++;
    if (ifa.out_data !== WA || ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_full: data=%h in_ready=%b valid=%b required %h/0/1",
               ifa.out_data, ifa.in_ready, ifa.out_valid, WA);
    end
    ifa.sel = 2'd2;
    tick();
    n_checks++;
    if (ifa.out_data !== WA || ifa.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_hold: data=%h in_ready=%b required %h/0", ifa.out_data, ifa.in_ready, WA);
    end
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    tick();
    n_checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== WB || ifa.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: valid=%b data=%h in_ready=%b required 1/%h/1",
               ifa.out_valid, ifa.out_data, ifa.in_ready, WB);
    end
    tick();
    n_checks++;
    if (ifa.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_no_dup: out_valid=%b data=%h required valid 0",
               ifa.out_valid, ifa.out_data);
    end
  endtask

  task automatic test_flush();
    ifa.in_bus    = {WC, WB, WA};
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.sel       = 2'd0;
    tick();
    ifa.sel = 2'd1;
    tick();
    n_checks++;
    if (ifa.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_setup: in_ready=%b required 0", ifa.in_ready);
    end
    ifa.sel = 2'd2;
    flush_a = 1'b1;
    tick();
    flush_a      = 1'b0;
    ifa.in_valid = 1'b0;
    n_checks++;
    if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_clear: valid=%b in_ready=%b required 0/1", ifa.out_valid, ifa.in_ready);
    end
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ifa.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_leak_%0d: out_valid=%b data=%h required valid 0",
                 i, ifa.out_valid, ifa.out_data);
      end
    end
  endtask

  task automatic test_reset_midstream();
    ifa.in_bus    = {WC, WB, WA};
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.sel       = 2'd2;
    tick();
    tick();
    ifa.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0 || ifa.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_async: valid=%b data=%h in_ready=%b required 0/0/0",
               ifa.out_valid, ifa.out_data, ifa.in_ready);
    end
    #1;
    rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    tick();
    n_checks++;
    if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_release: in_ready=%b valid=%b required 1/0", ifa.in_ready, ifa.out_valid);
    end
  endtask

  task automatic test_random();
    logic [8:0] q[$];
    logic [7:0] words [5];
    logic [8:0] exp_item, got_item;
    logic [7:0] prev_data;
    logic       prev_oor, stalled_prev, rdy0;
    int         s;
    stalled_prev = 1'b0;
    prev_data    = '0;
    prev_oor     = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < 5; k++) words[k] = 8'($urandom);
      s = int'($urandom_range(0, 7));
      ifb.in_bus    = {words[4], words[3], words[2], words[1], words[0]};
      ifb.sel       = 3'(s);
      ifb.in_valid  = ($urandom_range(0, 3) != 0);
      ifb.out_ready = ($urandom_range(0, 9) < 6);
      flush_b       = ($urandom_range(0, 299) == 0);
      rdy0 = ifb.in_ready;
      ifb.out_ready = !ifb.out_ready;
      #1;
      n_checks++;
      if (ifb.in_ready !== rdy0) begin
        n_err++;
        $display("FAIL rand_ready_path cyc=%0d: in_ready=%b required %b", cyc, ifb.in_ready, rdy0);
      end
      ifb.out_ready = !ifb.out_ready;
      #1;
      n_checks++;
      if (ifb.out_valid !== (q.size() > 0) || ifb.in_ready !== (q.size() < 2)) begin
        n_err++;
        $display("FAIL rand_occupancy cyc=%0d: valid=%b in_ready=%b required %b/%b",
                 cyc, ifb.out_valid, ifb.in_ready, q.size() > 0, q.size() < 2);
      end
      if (stalled_prev) begin
        n_checks++;
        if (ifb.out_data !== prev_data || ifb.out_oor !== prev_oor) begin
          n_err++;
          $display("FAIL rand_stable cyc=%0d: data=%h oor=%b required %h/%b",
                   cyc, ifb.out_data, ifb.out_oor, prev_data, prev_oor);
        end
      end
      if (flush_b) begin
        q.delete();
        stalled_prev = 1'b0;
      end else begin
        if (ifb.out_valid && ifb.out_ready) begin
          got_item = {ifb.out_oor, ifb.out_data};
          n_checks++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL rand_spurious cyc=%0d: emitted %h with empty model", cyc, got_item);
          end else begin
            exp_item = q.pop_front();
            if (got_item !== exp_item) begin
              n_err++;
              $display("FAIL rand_data cyc=%0d: got %h required %h", cyc, got_item, exp_item);
            end
          end
        end
        if (ifb.in_valid && ifb.in_ready) begin
          if (s < 5) q.push_back({1'b0, words[s]});
          else       q.push_back({1'b1, 8'h00});
        end
        stalled_prev = ifb.out_valid && !ifb.out_ready;
      end
      prev_data = ifb.out_data;
      prev_oor  = ifb.out_oor;
      tick();
    end
    flush_b      = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    test_reset();
    test_select();
    test_oor();
    test_stall();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
